fpadd: RTL and testbench

FPADD -- requirements
Module: fpadd

---
 rtl/fpadd.sv | 185 ++++++++++++++++++
 tb/tb_fpadd.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fpadd.sv
// fpadd: single-shot IEEE-754 binary32 adder, started by releasing reset.
// Latency: result and done registered on the 5th rising clk edge after reset falls.
// No backpressure: done/result hold in the terminal state until the next reset.
module fpadd (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [2:0] {S_LOAD, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;          // sign of the larger-magnitude operand
  logic               sub_q, sub_d;            // operand signs differ
  logic [23:0]        big_man_q, big_man_d;
  logic [23:0]        small_man_q, small_man_d;
  logic [7:0]         diff_q, diff_d;
  logic signed [9:0]  exp_q, exp_d;            // wide so under/overflow stay visible
  logic [26:0]        small_al_q, small_al_d;  // aligned small mantissa + guard/round/sticky
  logic [27:0]        sum_q, sum_d;            // raw sum, later the normalized mantissa
  logic               zero_q, zero_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;

  // operand classification and magnitude ordering, straight from the inputs
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0] big_op, small_op;
  logic        spec_now;
  logic [31:0] spec_now_res;

  // classify operands and resolve NaN/inf/zero shortcuts before any arithmetic
  always_comb begin
    a_zero = (dataa[30:23] == 8'h00);
    b_zero = (datab[30:23] == 8'h00);
    a_inf  = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
    b_inf  = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'd0);
    a_nan  = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
    b_nan  = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0);
    big_op   = (dataa[30:0] >= datab[30:0]) ? dataa : datab;
    small_op = (dataa[30:0] >= datab[30:0]) ? datab : dataa;
    spec_now     = 1'b1;
    spec_now_res = 32'h7FC00000;
    if (a_nan || b_nan)                          spec_now_res = 32'h7FC00000;
    else if (a_inf && b_inf && (dataa[31] != datab[31])) spec_now_res = 32'h7FC00000;
    else if (a_inf)                              spec_now_res = dataa;
    else if (b_inf)                              spec_now_res = datab;
    else if (a_zero && b_zero)                   spec_now_res = {dataa[31] & datab[31], 31'd0};
    else if (a_zero)                             spec_now_res = datab;
    else if (b_zero)                             spec_now_res = dataa;
    else                                         spec_now = 1'b0;
  end

  // leading-zero count of the 27-bit sum used by the left normalize
  logic [4:0] lzc;
  logic       lz_found;
  always_comb begin
    lzc      = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && sum_q[i]) begin
        lzc      = 5'(26 - i);
        lz_found = 1'b1;
      end
    end
  end

  // per-state datapath and next-state; every register holds unless its stage writes it
  logic [26:0] small_ext, shifted, mask;
  logic [24:0] man_rnd;
  logic        rnd_up;
  logic signed [9:0] exp_r;
  logic [23:0] man_f;
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    big_man_d   = big_man_q;
    small_man_d = small_man_q;
    diff_d      = diff_q;
    exp_d       = exp_q;
    small_al_d  = small_al_q;
    sum_d       = sum_q;
    zero_d      = zero_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    result_d    = result_q;
    done_d      = done_q;
    small_ext   = {small_man_q, 3'b000};
    shifted     = small_ext >> diff_q;
    mask        = (27'd1 << diff_q) - 27'd1;
    rnd_up      = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    man_rnd     = {1'b0, sum_q[26:3]} + {24'd0, rnd_up};
    exp_r       = exp_q + (man_rnd[24] ? 10'sd1 : 10'sd0);
    man_f       = man_rnd[24] ? man_rnd[24:1] : man_rnd[23:0];
    case (state_q)
      S_LOAD: begin
        sign_d      = big_op[31];
        sub_d       = dataa[31] ^ datab[31];
        big_man_d   = {1'b1, big_op[22:0]};
        small_man_d = {1'b1, small_op[22:0]};
        diff_d      = big_op[30:23] - small_op[30:23];
        exp_d       = $signed({2'b00, big_op[30:23]});
        spec_d      = spec_now;
        spec_res_d  = spec_now_res;
        state_d     = S_ALIGN;
      end
      S_ALIGN: begin
        if (diff_q >= 8'd26) small_al_d = {26'd0, |small_man_q};
        else                 small_al_d = shifted | {26'd0, |(small_ext & mask)};
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sub_q) sum_d = {1'b0, big_man_q, 3'b000} - {1'b0, small_al_q};
        else       sum_d = {1'b0, big_man_q, 3'b000} + {1'b0, small_al_q};
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q[27]) begin
          sum_d = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d = exp_q + 10'sd1;
        end else if (sum_q == 28'd0) begin
          zero_d = 1'b1;
        end else begin
          sum_d = {1'b0, sum_q[26:0] << lzc};
          exp_d = exp_q - $signed({5'd0, lzc});
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        if (spec_q)                 result_d = spec_res_q;
        else if (zero_q)            result_d = 32'h00000000;
        else if (exp_r >= 10'sd255) result_d = {sign_q, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)   result_d = {sign_q, 31'd0};
        else                        result_d = {sign_q, exp_r[7:0], man_f[22:0]};
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_DONE;
    endcase
  end

  // state register; reset clears everything at once and re-arms the LOAD step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      big_man_q   <= '0;
      small_man_q <= '0;
      diff_q      <= '0;
      exp_q       <= '0;
      small_al_q  <= '0;
      sum_q       <= '0;
      zero_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      big_man_q   <= big_man_d;
      small_man_q <= small_man_d;
      diff_q      <= diff_d;
      exp_q       <= exp_d;
      small_al_q  <= small_al_d;
      sum_q       <= sum_d;
      zero_q      <= zero_d;
      spec_q      <= spec_d;
      spec_res_q  <= spec_res_d;
      result_q    <= result_d;
      done_q      <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fpadd.sv
// Bench for fpadd: directed binary32 vectors with hand-computed sums.
// Stimulus pushes expected results into a queue; a negedge monitor pops on done.
// Also checks reset clearing, 5-edge latency, result hold and mid-operation abort.
module tb_fpadd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic [31:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];
  int   edge_cnt;
  logic done_prev = 1'b0;
  logic [31:0] last_res = 32'd0;

  fpadd dut (
    .clk   (clk),
    .reset (reset),
    .dataa (dataa),
    .datab (datab),
    .result(result),
    .done  (done)
  );

  always #5 clk = ~clk;

  // rising edges since reset was released
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // monitor: on done rising, check latency and pop the scoreboard; afterwards check hold
  always @(negedge clk) begin
    if (!reset && done) begin
      if (!done_prev) begin
        total++;
        if (edge_cnt != 5) begin
          bad++;
          $display("FAIL latency: done rose after %0d edges, required 5", edge_cnt);
        end
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: result=%08h with empty scoreboard", result);
        end else begin
          logic [31:0] exp_v;
          exp_v = sb_q.pop_front();
          if (result !== exp_v) begin
            bad++;
            $display("FAIL result: got %08h required %08h", result, exp_v);
          end
        end
        last_res = result;
      end else begin
        total++;
        if (result !== last_res) begin
          bad++;
          $display("FAIL hold: result %08h changed from %08h while done", result, last_res);
        end
      end
    end
    done_prev = done;
  end

  task automatic check_cleared(input string tag);
    total++;
    if (done !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL %s: done=%b result=%08h required done=0 result=00000000", tag, done, result);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    reset = 1'b1;
    dataa = a;
    datab = b;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL timeout: %0d expected results never produced", sb_q.size());
      sb_q.delete();
    end
    sb_q.push_back(e);
    #1 check_cleared("reset_clear");
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    start_op(a, b, e);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // operands were captured on the first edge; later changes must be ignored
    dataa = $urandom;
    datab = $urandom;
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[] = '{
    '{32'h3FC00000, 32'h3FA00000, 32'h40300000},  // 1.5 + 1.25 = 2.75
    '{32'h3FC00000, 32'hBFA00000, 32'h3E800000},  // 1.5 - 1.25 = 0.25
    '{32'h3D800000, 32'h3F800000, 32'h3F880000},  // 0.0625 + 1
    '{32'h3D800000, 32'h3D800000, 32'h3E000000},  // carry-out
    '{32'h3F800000, 32'hBF800000, 32'h00000000},  // x + -x
    '{32'h7F800000, 32'hFF800000, 32'h7FC00000},  // inf - inf
    '{32'h3F800000, 32'h33800000, 32'h3F800000},  // tie, even stays
    '{32'h3F800001, 32'h33800000, 32'h3F800002},  // tie, odd rounds up
    '{32'h3FFFFFFF, 32'h33800000, 32'h40000000},  // rounding carry
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000},  // NaN input
    '{32'h3F800000, 32'h7F800000, 32'h7F800000},  // finite + inf
    '{32'h00000000, 32'hC0400000, 32'hC0400000},  // 0 + x
    '{32'h80000000, 32'h80000000, 32'h80000000},  // -0 + -0
    '{32'h00000000, 32'h80000000, 32'h00000000},  // +0 + -0
    '{32'h00000001, 32'h3F800000, 32'h3F800000},  // denormal as zero
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},  // overflow
    '{32'h00800001, 32'h80800000, 32'h00000000},  // underflow flush
    '{32'h3F800000, 32'hC0000000, 32'hBF800000}   // 1 - 2 = -1
  };

  initial begin
    @(negedge clk);
    #1 check_cleared("initial_reset");
    foreach (vecs[i]) run_vec(vecs[i].a, vecs[i].b, vecs[i].e);

    // abort: reset two edges into an operation, restart with new operands
    start_op(32'h3FC00000, 32'h3FA00000, 32'h40300000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dataa = 32'h3D800000;
    datab = 32'h3F800000;
    void'(sb_q.pop_back());
    sb_q.push_back(32'h3F880000);
    #1 check_cleared("abort_clear");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // reset while in the terminal state clears done and result at once
    reset = 1'b1;
    #1 check_cleared("done_clear");
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL timeout: %0d expected results never produced", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
